instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the control-decode path. Accepts decoded instruction fields (format, opcode, register numbers, immediate or target) over a valid/ready handshake.
- Packs each instruction into a 32-bit MIPS word, checks it against the opcode set the core's controller supports, and writes legal words into instruction memory at consecutive addresses.
- Serves as the program loader/self-test generator that feeds the core's instruction memory.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- BASE_ADDR, 0, first write address after reset or start.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse: restart load at BASE_ADDR, clear count/error, flush pending word.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle this cycle.
- fmt  in  2  00 R-type, 01 I-type, 10 J-type, 11 illegal.
- opcode  in  6  instruction opcode.
- rs, rt, rd, shamt  in  5 each  register/shift fields.
- funct  in  6  R-type function.
- imm  in  16  I-type immediate.
- target  in  26  J-type target.
- imem_we  out  1  write request, doubles as output-valid.
- imem_ready  in  1  memory accepts the write this cycle.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  32  encoded word.
- count  out  ADDR_W+1  words written since start/reset.
- mem_full  out  1  last address written; loading halted.
- err  out  1  sticky: a bundle was rejected.
- err_code  out  2  cause of first rejection: 01 unsupported opcode, 10 format mismatch, 11 $0 destination (optional feature).

Behaviour:
- Reset values: in_ready=0 during reset, 1 in the cycle after. imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, count=0, mem_full=0, err=0, err_code=00.
- Word packing:
  - R-type: {opcode,rs,rt,rd,shamt,funct}.
  - I-type: {opcode,rs,rt,imm}.
  - J-type: {opcode,target}.
- Legal opcodes and required fmt:
  - 000000 → R.
  - 000010 and 000011 → J.
  - 001010, 100011, 101011, 001000, 110011 → I.
- Rejection:
  - Any other opcode, or fmt=11, gives err_code 01.
  - A legal opcode with the wrong fmt gives err_code 10.
  - A rejected bundle is consumed without a write; address and count are unchanged. err is set; err_code latches only on the first error.
- Handshake and state:
  - Accept when in_valid && in_ready.
  - in_ready = !reset && !start && !mem_full && (!imem_we || imem_ready).
  - Legal word appears with imem_we=1 in the cycle after acceptance (latency 1).
  - imem_we, imem_addr and imem_wdata are held stable until imem_ready=1.
  - Throughput is 1 word/cycle while imem_ready stays high.
- Write completion (imem_we && imem_ready):
  - imem_addr increments and count increments.
  - If the completed address was 2^ADDR_W-1, mem_full=1: the address wraps to BASE_ADDR, but no further acceptance until start.
- State machine:
  - EMPTY → PEND on a legal accept.
  - PEND → PEND on a write completing together with a new legal accept.
  - PEND → EMPTY on a write completing with no legal accept.
  - Any state → HALT on the last address.
  - HALT → EMPTY on start.
- Simultaneous events:
  - start in the same cycle as in_valid: start wins, no accept.
  - start in the same cycle as a completing write: the write is counted in memory, but count/address reset anyway.
- Reset mid-pending write drops the word; imem_we=0 the next cycle.

Optional Feature:
- INSTR_ENC_R0_GUARD_EN defined:
  - Rejects bundles that write $0 (R-type rd=0; opcodes 001010/100011/001000/110011 with rt=0) with err_code 11.
  - The all-zero word (nop) is exempt.
- Undefined: such bundles are encoded and written normally.

Decomposition:
- Package instr_enc_pkg holds:
  - opcode localparams OP_RTYPE, OP_SLTI, OP_J, OP_JAL, OP_LW, OP_SW, OP_ADDI, OP_PERF;
  - FMT_R/I/J codes;
  - ERR_OPCODE/ERR_FMT/ERR_R0 codes.
- One combinational sub-module, instr_pack: fields in, 32-bit word plus legal flag plus err_code out. The top holds the handshake, FSM, counters and sticky error.

Test Plan:
- add $3,$1,$2 (R, op 0, rs1 rt2 rd3 shamt0 funct 0x20) then lw $4,8($1) with imem_ready=1 → 0x00221820 at addr 0, then 0x8C240008 at addr 1; count=2.
- addi $5,$0,0xFFFF with imem_ready low 3 cycles → imem_we=1, wdata 0x2005FFFF, addr stable, in_ready=0 for 3 cycles; write completes on cycle 4.
- opcode 000100 fmt I → err=1, err_code=01, no imem_we, addr unchanged; following jal target 0x40 (fmt J) writes 0x0C000040 and err_code stays 01.
- j with fmt I after reset → err_code=10, no write.
- ADDR_W=2: 4 legal words → mem_full=1 after the 4th write, in_ready=0; start pulse → addr 0, count 0, err 0, mem_full 0.
- reset asserted while PEND → next cycle imem_we=0, count=0, addr=BASE_ADDR.

Source files
------------

// File: rtl/instr_enc_pkg.sv
// ============================================================
// instr_enc_pkg: opcode, format and error codes for instr_encoder
// Rev 1.0
// ============================================================
`default_nettype none

package instr_enc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_PERF  = 6'b110011;

  localparam logic [1:0] FMT_R   = 2'b00;
  localparam logic [1:0] FMT_I   = 2'b01;
  localparam logic [1:0] FMT_J   = 2'b10;
  localparam logic [1:0] FMT_BAD = 2'b11;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_OPCODE = 2'b01;
  localparam logic [1:0] ERR_FMT    = 2'b10;
  localparam logic [1:0] ERR_R0     = 2'b11;

  // {supported, required format} for an opcode
  function automatic logic [2:0] op_fmt(input logic [5:0] op);
    case (op)
      OP_RTYPE:                               op_fmt = {1'b1, FMT_R};
      OP_J, OP_JAL:                           op_fmt = {1'b1, FMT_J};
      OP_SLTI, OP_LW, OP_SW, OP_ADDI, OP_PERF: op_fmt = {1'b1, FMT_I};
      default:                                op_fmt = {1'b0, FMT_BAD};
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_pack.sv
// ============================================================
// instr_pack: packs decoded fields into a MIPS word and classifies it.
// INSTR_ENC_R0_GUARD_EN: reject non-nop bundles that write $0.
// Rev 1.0
// ============================================================
`default_nettype none

module instr_pack
  import instr_enc_pkg::*;
(
  input  logic [1:0]  fmt,
  input  logic [5:0]  opcode,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        legal,
  output logic [1:0]  err_code
);

  logic [2:0] req;

  always_comb begin
    word     = '0;
    legal    = 1'b0;
    err_code = ERR_NONE;
    req      = op_fmt(opcode);
    case (fmt)
      FMT_R:   word = {opcode, rs, rt, rd, shamt, funct};
      FMT_I:   word = {opcode, rs, rt, imm};
      FMT_J:   word = {opcode, target};
      default: word = '0;
    endcase
    if (fmt == FMT_BAD || !req[2]) begin
      err_code = ERR_OPCODE;
    end else if (fmt != req[1:0]) begin
      err_code = ERR_FMT;
`ifdef INSTR_ENC_R0_GUARD_EN
    end else if (word != '0 &&
                 ((fmt == FMT_R && rd == '0) ||
                  (fmt == FMT_I && opcode != OP_SW && rt == '0))) begin
      err_code = ERR_R0;
`endif
    end else begin
      legal = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_encoder.sv
// ============================================================
// instr_encoder: encodes field bundles and loads them into imem.
// INSTR_ENC_R0_GUARD_EN: enables the $0-destination guard in instr_pack.
// Rev 1.0
// ============================================================
`default_nettype none

module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [5:0]        opcode,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              mem_full,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_PEND  = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [1:0]        code_q, code_d;

  logic [31:0] pk_word;
  logic        pk_legal;
  logic [1:0]  pk_err;
  logic        accept, complete, last_done, take;

  instr_pack u_pack (
    .fmt      (fmt),
    .opcode   (opcode),
    .rs       (rs),
    .rt       (rt),
    .rd       (rd),
    .shamt    (shamt),
    .funct    (funct),
    .imm      (imm),
    .target   (target),
    .word     (pk_word),
    .legal    (pk_legal),
    .err_code (pk_err)
  );

  assign imem_we    = (state_q == ST_PEND);
  assign mem_full   = (state_q == ST_HALT);
  assign in_ready   = !reset && !start && !mem_full && (!imem_we || imem_ready);
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign err        = err_q;
  assign err_code   = code_q;

  assign accept    = in_valid && in_ready;
  assign complete  = imem_we && imem_ready;
  assign last_done = complete && (addr_q == LAST_ADDR);
  // A word accepted alongside the final write has nowhere to go and is dropped
  assign take      = accept && pk_legal && !last_done;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    code_d  = code_q;

    if (complete) begin
      addr_d  = last_done ? BASE : addr_q + ADDR_ONE;
      count_d = count_q + CNT_ONE;
    end
    if (take) begin
      wdata_d = pk_word;
    end
    if (accept && !pk_legal) begin
      err_d = 1'b1;
      if (!err_q) code_d = pk_err;
    end

    case (state_q)
      ST_EMPTY: if (take) state_d = ST_PEND;
      ST_PEND: begin
        if (last_done)     state_d = ST_HALT;
        else if (complete) state_d = take ? ST_PEND : ST_EMPTY;
      end
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_EMPTY;
    endcase

    if (start) begin
      state_d = ST_EMPTY;
      addr_d  = BASE;
      count_d = '0;
      err_d   = 1'b0;
      code_d  = ERR_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      addr_q  <= BASE;
      count_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================
// tb_instr_encoder: directed and random checks of instr_encoder
// Rev 1.0
// ============================================================
`default_nettype none

module tb_instr_encoder;

  localparam int AW   = 4;
  localparam int BASE = 2;
  localparam int LAST = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          reset, start, in_valid, in_ready;
  logic [1:0]    fmt;
  logic [5:0]    opcode, funct;
  logic [4:0]    rs, rt, rd, shamt;
  logic [15:0]   imm;
  logic [25:0]   target;
  logic          imem_we, imem_ready, mem_full, err;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   count;
  logic [1:0]    err_code;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .funct(funct), .imm(imm), .target(target), .imem_we(imem_we),
    .imem_ready(imem_ready), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .count(count), .mem_full(mem_full), .err(err), .err_code(err_code)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: next write address, words written, one pending word
  int          m_addr, m_count;
  bit          m_pend, m_full, m_err, m_rdy;
  logic [1:0]  m_code;
  logic [31:0] m_wdata;

  logic [5:0] legal_ops [8] = '{6'h00, 6'h02, 6'h03, 6'h0A, 6'h23, 6'h2B, 6'h08, 6'h33};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int required_fmt(input logic [5:0] op);
    case (op)
      6'h00:                             return 0;
      6'h02, 6'h03:                      return 2;
      6'h0A, 6'h23, 6'h2B, 6'h08, 6'h33: return 1;
      default:                           return -1;
    endcase
  endfunction

  function automatic logic [1:0] classify(input logic [1:0] f, input logic [5:0] op);
    int r = required_fmt(op);
    if (f == 2'b11 || r < 0) return 2'b01;
    if (int'(f) != r)        return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] encode();
    logic [31:0] w;
    if (fmt == 2'b00)      w = (32'(opcode) << 26) | (32'(rs) << 21) | (32'(rt) << 16)
                             | (32'(rd) << 11) | (32'(shamt) << 6) | 32'(funct);
    else if (fmt == 2'b01) w = (32'(opcode) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
    else                   w = (32'(opcode) << 26) | 32'(target);
    return w;
  endfunction

  // One clock: inputs are already driven; predict, clock, compare.
  task automatic step();
    logic [1:0] c;
    #1;
    m_rdy = !reset && !start && !m_full && (!m_pend || imem_ready);
    check("in_ready", in_ready, m_rdy);
    c = classify(fmt, opcode);
    if (reset) begin
      m_addr = BASE; m_count = 0; m_pend = 0; m_full = 0; m_err = 0; m_code = 0; m_wdata = 0;
    end else if (start) begin
      m_addr = BASE; m_count = 0; m_pend = 0; m_full = 0; m_err = 0; m_code = 0;
    end else begin
      if (m_pend && imem_ready) begin
        m_pend = 0;
        m_count++;
        if (m_addr == LAST) begin m_full = 1; m_addr = BASE; end
        else m_addr++;
      end
      if (in_valid && m_rdy) begin
        if (c == 2'b00) begin
          if (!m_full) begin m_pend = 1; m_wdata = encode(); end
        end else begin
          if (!m_err) m_code = c;
          m_err = 1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("imem_we", imem_we, m_pend);
    check("imem_addr", imem_addr, m_addr);
    check("imem_wdata", imem_wdata, m_wdata);
    check("count", count, m_count);
    check("mem_full", mem_full, m_full);
    check("err", err, m_err);
    check("err_code", err_code, m_code);
  endtask

  task automatic set_r(input logic [4:0] s, t, d, input logic [5:0] fn);
    fmt = 2'b00; opcode = 6'h00; rs = s; rt = t; rd = d; shamt = 0; funct = fn;
  endtask

  task automatic set_i(input logic [5:0] op, input logic [4:0] s, t, input logic [15:0] im);
    fmt = 2'b01; opcode = op; rs = s; rt = t; imm = im;
  endtask

  task automatic set_j(input logic [1:0] f, input logic [5:0] op, input logic [25:0] tg);
    fmt = f; opcode = op; target = tg;
  endtask

  task automatic rand_fields();
    int k = $urandom_range(0, 9);
    if (k < 8) begin
      opcode = legal_ops[k];
      if ($urandom_range(0, 9) < 9) fmt = 2'(required_fmt(opcode));
      else fmt = 2'($urandom);
    end else begin
      opcode = 6'($urandom);
      fmt = 2'($urandom);
    end
    rs = 5'($urandom); shamt = 5'($urandom); funct = 6'($urandom);
    rt = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    imm = 16'($urandom); target = 26'($urandom);
  endtask

  initial begin
    reset = 1; start = 0; in_valid = 0; imem_ready = 1;
    fmt = 0; opcode = 0; rs = 0; rt = 0; rd = 0; shamt = 0; funct = 0; imm = 0; target = 0;
    @(negedge clk);
    step();
    check("rst_addr", imem_addr, BASE);
    check("rst_we", imem_we, 0);
    reset = 0;
    step();

    // add $3,$1,$2 then lw $4,8($1), memory always ready
    in_valid = 1; set_r(1, 2, 3, 6'h20);
    step();
    check("add_word", imem_wdata, 32'h00221820);
    check("add_addr", imem_addr, BASE);
    set_i(6'h23, 1, 4, 16'h0008);
    step();
    check("lw_word", imem_wdata, 32'h8C240008);
    check("lw_addr", imem_addr, BASE + 1);
    in_valid = 0;
    step();
    check("count2", count, 2);

    // addi $5,$0,0xFFFF with memory stalled three cycles
    imem_ready = 0; in_valid = 1; set_i(6'h08, 0, 5, 16'hFFFF);
    step();
    in_valid = 0;
    check("addi_word", imem_wdata, 32'h2005FFFF);
    for (int i = 0; i < 3; i++) begin
      step();
      check("addi_hold", imem_addr, BASE + 2);
    end
    imem_ready = 1;
    step();
    check("addi_done", count, 3);

    // unsupported opcode, then jal still writes and first cause sticks
    in_valid = 1; set_i(6'h04, 1, 2, 16'h0010);
    step();
    check("bad_op_code", err_code, 2'b01);
    set_j(2'b10, 6'h03, 26'h40);
    step();
    check("jal_word", imem_wdata, 32'h0C000040);
    in_valid = 0;
    step();
    check("code_sticky", err_code, 2'b01);

    // j with I format after reset
    reset = 1;
    step();
    reset = 0; in_valid = 1; set_j(2'b01, 6'h02, 26'h123);
    step();
    check("fmt_code", err_code, 2'b10);
    check("fmt_nowrite", imem_we, 0);

    // fill every address from BASE up to the top, then restart
    set_r(1, 2, 3, 6'h20);
    for (int i = 0; i < LAST - BASE + 1; i++) step();
    in_valid = 0;
    step();
    check("full", mem_full, 1);
    check("full_count", count, LAST - BASE + 1);
    start = 1;
    step();
    start = 0;
    step();
    check("start_addr", imem_addr, BASE);
    check("start_err", err, 0);

    // reset while a word is pending
    imem_ready = 0; in_valid = 1; set_i(6'h2B, 3, 7, 16'h0004);
    step();
    in_valid = 0; reset = 1;
    step();
    check("rst_pend_we", imem_we, 0);
    reset = 0; imem_ready = 1;
    step();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset      = ($urandom_range(0, 99) == 0);
      start      = ($urandom_range(0, 49) == 0);
      in_valid   = ($urandom_range(0, 9) < 7);
      imem_ready = ($urandom_range(0, 9) < 7);
      rand_fields();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
